// File: rtl/shift_add_mult_8_bit_pkg.sv
// ----------------------------------------------------------------------------
// shift_add_mult_8_bit_pkg
// Shared definitions for the sequential 8x8 shift-and-add multiplier:
// operand/product widths, FSM state encoding and the fixed step count.
// No ports (package).
// ----------------------------------------------------------------------------
package shift_add_mult_8_bit_pkg;

    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned PROD_W    = 16;

    // One RUN step per multiplier bit; the run never terminates early.
    localparam int unsigned STEPS     = 8;
    localparam logic [2:0]  LAST_STEP = 3'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage : shift_add_mult_8_bit_pkg

// File: rtl/shift_add_mult_8_bit_rca.sv
// ----------------------------------------------------------------------------
// rca_16_bit
// 16-bit ripple-carry adder built from a chain of full-adder cells. Purely
// combinational; it is the only arithmetic resource of the multiplier.
//
// Ports:
//   a_i    [15:0]  in   addend
//   b_i    [15:0]  in   addend
//   cin_i          in   carry in
//   sum_o  [15:0]  out  a_i + b_i + cin_i (low 16 bits)
//   cout_o         out  carry out of bit 15
// ----------------------------------------------------------------------------
module rca_16_bit
    import shift_add_mult_8_bit_pkg::*;
(
    input  logic [PROD_W-1:0] a_i,
    input  logic [PROD_W-1:0] b_i,
    input  logic              cin_i,
    output logic [PROD_W-1:0] sum_o,
    output logic              cout_o
);

    logic [PROD_W:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < PROD_W; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[PROD_W];

endmodule : rca_16_bit

// File: rtl/shift_add_mult_8_bit.sv
// ----------------------------------------------------------------------------
// shift_add_mult_8_bit
// Sequential unsigned 8x8 -> 16 shift-and-add multiplier. Each RUN cycle the
// ripple-carry adder sums the partial product with the shifted multiplicand;
// the sum is kept only when the current multiplier LSB is 1. Every multiply
// takes exactly 8 RUN cycles, followed by a one-cycle DONE.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset (priority over start)
//   start           in   begin a multiply; accepted in IDLE or DONE only
//   a       [7:0]   in   multiplicand, sampled on the accepting edge
//   b       [7:0]   in   multiplier, sampled on the accepting edge
//   busy            out  high while in RUN
//   done            out  one-cycle pulse when product is updated
//   product [15:0]  out  last completed result, held between completions
// ----------------------------------------------------------------------------
module shift_add_mult_8_bit
    import shift_add_mult_8_bit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [PROD_W-1:0]    product
);

    state_e                state_q;
    logic [PROD_W-1:0]     acc_q;
    logic [PROD_W-1:0]     acc_d;
    logic [PROD_W-1:0]     mcand_q;
    logic [OPERAND_W-1:0]  mplier_q;
    logic [2:0]            cnt_q;
    logic [PROD_W-1:0]     product_q;
    logic                  busy_q;
    logic                  done_q;

    logic [PROD_W-1:0]     adder_sum;
    // The partial product plus the shifted multiplicand never exceeds 16 bits,
    // so the carry out carries no information here.
    logic                  unused_adder_cout;

    rca_16_bit u_rca (
        .a_i    (acc_q),
        .b_i    (mcand_q),
        .cin_i  (1'b0),
        .sum_o  (adder_sum),
        .cout_o (unused_adder_cout)
    );

    // Keep the adder result only when the current multiplier bit is set.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = adder_sum;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                // IDLE and DONE both accept start, giving back-to-back runs.
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= {{(PROD_W - OPERAND_W){1'b0}}, a};
                        mplier_q <= b;
                        cnt_q    <= '0;
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                    end
                end

                S_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 3'd1;
                    // Publish the sum including this step's add, not acc_q.
                    if (cnt_q == LAST_STEP) begin
                        product_q <= acc_d;
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : shift_add_mult_8_bit

// File: tb/tb_shift_add_mult_8_bit.sv
// ----------------------------------------------------------------------------
// tb_shift_add_mult_8_bit
// Directed and random checks of the shift-and-add multiplier against a plain
// arithmetic reference (a * b). Timing model: the edge that accepts start is
// E0; busy is seen high after E0..E7, and after E8 done is high with the new
// product. The adder carry-out must stay 0 throughout every run.
// ----------------------------------------------------------------------------
module tb_shift_add_mult_8_bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;

    // Reference state: result of the last completed multiply.
    logic [15:0] last_product;

    shift_add_mult_8_bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one edge and sample 1 time unit later; the carry-out of the
    // accumulate adder is checked on every cycle spent in RUN.
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy === 1'b1) begin
            check("adder_cout", {15'b0, dut.unused_adder_cout}, 16'd0);
        end
    endtask

    function automatic logic [15:0] ref_mult(input logic [7:0] x, input logic [7:0] y);
        return {8'b0, x} * {8'b0, y};
    endfunction

    // Complete single-start multiply with full cycle-by-cycle checking.
    task automatic run_mult(input logic [7:0] ma, input logic [7:0] mb, input string tag);
        logic [15:0] exp_p;
        exp_p = ref_mult(ma, mb);
        start = 1'b1;
        a     = ma;
        b     = mb;
        tick();                               // E0
        start = 1'b0;
        a     = 8'($urandom);                 // operands may change freely now
        b     = 8'($urandom);
        for (int i = 1; i <= 8; i++) begin
            check({tag, "_busy"}, {15'b0, busy}, 16'd1);
            check({tag, "_done_low"}, {15'b0, done}, 16'd0);
            check({tag, "_held"}, product, last_product);
            tick();                           // E1..E8
        end
        check({tag, "_done"}, {15'b0, done}, 16'd1);
        check({tag, "_busy_end"}, {15'b0, busy}, 16'd0);
        check({tag, "_product"}, product, exp_p);
        last_product = exp_p;
        tick();
        check({tag, "_done_pulse"}, {15'b0, done}, 16'd0);
        check({tag, "_after"}, product, last_product);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        a            = '0;
        b            = '0;
        last_product = '0;

        // Reset then idle.
        tick();
        tick();
        check("rst_product", product, 16'd0);
        check("rst_busy", {15'b0, busy}, 16'd0);
        check("rst_done", {15'b0, done}, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_busy", {15'b0, busy}, 16'd0);
            check("idle_done", {15'b0, done}, 16'd0);
            check("idle_product", product, 16'd0);
        end

        // Basic multiply and extremes.
        run_mult(8'd13, 8'd11, "basic");
        check("basic_143", last_product, 16'd143);
        run_mult(8'd255, 8'd255, "max");
        run_mult(8'd0, 8'd200, "zero");
        run_mult(8'd1, 8'd1, "one");

        // Busy protection: a start pulse in RUN step 3 is ignored.
        start = 1'b1; a = 8'd7; b = 8'd9;
        tick();                               // E0
        start = 1'b0;
        tick(); tick(); tick();               // E3: counter now at step 3
        start = 1'b1; a = 8'd100; b = 8'd100;
        tick();                               // E4: must be ignored
        start = 1'b0;
        check("prot_busy", {15'b0, busy}, 16'd1);
        tick(); tick(); tick();               // E7
        check("prot_not_done", {15'b0, done}, 16'd0);
        tick();                               // E8
        check("prot_done", {15'b0, done}, 16'd1);
        check("prot_product", product, ref_mult(8'd7, 8'd9));
        last_product = ref_mult(8'd7, 8'd9);
        tick();
        check("prot_idle", {15'b0, busy}, 16'd0);

        // Back-to-back: start held high, results 9 edges apart.
        start = 1'b1; a = 8'd3; b = 8'd5;
        tick();                               // E0
        a = 8'd6; b = 8'd7;                   // sampled only at next acceptance
        for (int i = 0; i < 8; i++) tick();   // E8
        check("b2b_done1", {15'b0, done}, 16'd1);
        check("b2b_prod1", product, 16'd15);
        for (int i = 0; i < 8; i++) begin
            tick();                           // E9..E16: second run
            check("b2b_busy2", {15'b0, busy}, 16'd1);
            check("b2b_hold", product, 16'd15);
        end
        start = 1'b0;
        tick();                               // E17
        check("b2b_done2", {15'b0, done}, 16'd1);
        check("b2b_prod2", product, 16'd42);
        last_product = 16'd42;
        tick();
        check("b2b_idle", {15'b0, busy}, 16'd0);

        // Reset mid-run aborts and clears product.
        start = 1'b1; a = 8'd200; b = 8'd3;
        tick();                               // E0
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();   // step 4
        rst = 1'b1;
        tick();
        check("mid_rst_product", product, 16'd0);
        check("mid_rst_busy", {15'b0, busy}, 16'd0);
        check("mid_rst_done", {15'b0, done}, 16'd0);
        rst = 1'b0;
        last_product = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_rst_no_done", {15'b0, done}, 16'd0);
        end
        run_mult(8'd2, 8'd2, "post_rst");

        // Random operands with random idle gaps.
        for (int n = 0; n < 12; n++) begin
            run_mult(8'($urandom), 8'($urandom), "rand");
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck run; the directed sequence needs far fewer cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_shift_add_mult_8_bit
